// File: rtl/seat_pkg.sv
// Shared types and constants for the seat request front-end.
package seat_pkg;

   localparam int unsigned MIN_PER_DAY = 1440;
   localparam int unsigned TIME_W      = 11;

   typedef enum logic [1:0] {
      LEAVE  = 2'd0,
      AWAY   = 2'd1,
      OCCUPY = 2'd2,
      RSVD   = 2'd3
   } seat_state_t;

   typedef struct packed {
      logic [31:0] student_no;
      logic [4:0]  seat_no;
      seat_state_t seat_state;
   } seat_req_t;

endpackage

// File: rtl/seat_req_fifo.sv
// Small synchronous FIFO of seat requests; DEPTH must be a power of two.
module seat_req_fifo
   import seat_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  seat_req_t wdata,
   output seat_req_t rdata,
   output logic      full,
   output logic      empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   seat_req_t       mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full    = (cnt_q == (AW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/seat_request_sequencer.sv
// Two-kiosk seat request front-end: round-robin arbiter, validator, FIFO,
// spaced write strobe generator and minute-of-day counter.
module seat_request_sequencer
   import seat_pkg::*;
#(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned NUM_SEATS    = 31,
   parameter int unsigned CLKS_PER_MIN = 60,
   parameter int unsigned GAP          = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              k0_valid,
   output logic              k0_ready,
   input  logic [31:0]       k0_student_no,
   input  logic [4:0]        k0_seat_no,
   input  logic [1:0]        k0_seat_state,
   input  logic              k1_valid,
   output logic              k1_ready,
   input  logic [31:0]       k1_student_no,
   input  logic [4:0]        k1_seat_no,
   input  logic [1:0]        k1_seat_state,
   input  logic              time_load,
   input  logic [TIME_W-1:0] time_value,
   output logic              write,
   output logic [31:0]       Student_No,
   output logic [4:0]        Seat_No,
   output logic [1:0]        Seat_State,
   output logic [TIME_W-1:0] Time,
   output logic [7:0]        drop_cnt,
   output logic              fifo_full
);

   localparam int unsigned PW = (CLKS_PER_MIN > 1) ? $clog2(CLKS_PER_MIN) : 1;
   localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [TIME_W-1:0] TIME_MAX = TIME_W'(MIN_PER_DAY - 1);

   logic              ptr_q, ptr_d;
   logic              grant;
   logic              accept, req_ok, push, issue;
   logic              fifo_empty;
   seat_req_t         req, head;
   seat_req_t         out_q, out_d;
   logic              write_q, write_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [7:0]        drop_q, drop_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [TIME_W-1:0] time_q, time_d;

   // Arbiter: a lone requester wins, otherwise the round-robin pointer decides.
   always_comb begin
      if (k0_valid && !k1_valid)      grant = 1'b0;
      else if (k1_valid && !k0_valid) grant = 1'b1;
      else                            grant = ptr_q;
   end

   assign k0_ready = !fifo_full && !grant;
   assign k1_ready = !fifo_full && grant;
   assign accept   = (k0_valid && k0_ready) || (k1_valid && k1_ready);

   always_comb begin
      if (grant) begin
         req.student_no = k1_student_no;
         req.seat_no    = k1_seat_no;
         req.seat_state = seat_state_t'(k1_seat_state);
      end else begin
         req.student_no = k0_student_no;
         req.seat_no    = k0_seat_no;
         req.seat_state = seat_state_t'(k0_seat_state);
      end
   end

   assign req_ok = (req.seat_no != '0) && (32'(req.seat_no) <= NUM_SEATS) &&
                   (req.seat_state != RSVD);
   assign push   = accept && req_ok;
   assign issue  = !fifo_empty && (gap_q == '0);

   seat_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (issue),
      .wdata (req),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      ptr_d   = ptr_q;
      out_d   = out_q;
      write_d = 1'b0;
      gap_d   = gap_q;
      drop_d  = drop_q;
      if (accept) ptr_d = ~ptr_q;
      if (accept && !req_ok && (drop_q != 8'hff)) drop_d = drop_q + 8'd1;
      if (issue) begin
         out_d   = head;
         write_d = 1'b1;
         gap_d   = GW'(GAP);
      end else if (gap_q != '0) begin
         gap_d = gap_q - GW'(1);
      end
   end

   // Minute counter: a load wins over the prescaler wrap on the same edge.
   always_comb begin
      presc_d = presc_q;
      time_d  = time_q;
      if (time_load) begin
         presc_d = '0;
         time_d  = (time_value > TIME_MAX) ? TIME_MAX : time_value;
      end else if (presc_q == PW'(CLKS_PER_MIN - 1)) begin
         presc_d = '0;
         time_d  = (time_q == TIME_MAX) ? '0 : time_q + TIME_W'(1);
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= 1'b0;
         out_q   <= '0;
         write_q <= 1'b0;
         gap_q   <= '0;
         drop_q  <= '0;
         presc_q <= '0;
         time_q  <= '0;
      end else begin
         ptr_q   <= ptr_d;
         out_q   <= out_d;
         write_q <= write_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
         presc_q <= presc_d;
         time_q  <= time_d;
      end
   end

   assign write      = write_q;
   assign Student_No = out_q.student_no;
   assign Seat_No    = out_q.seat_no;
   assign Seat_State = out_q.seat_state;
   assign Time       = time_q;
   assign drop_cnt   = drop_q;

endmodule
